// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: rule/srcmd/mdcfg tables, error capture record,
// plus the etype/ttype codes and state enum used by the sequential checker.
package rv_iopmp_pkg;

  localparam int MD_BITS = 31;

  typedef enum logic [2:0] {
    ACCESS_NONE      = 3'b000,
    ACCESS_READ      = 3'b001,
    ACCESS_WRITE     = 3'b010,
    ACCESS_EXECUTION = 3'b100
  } access_t;

  typedef enum logic [1:0] {
    ADDR_OFF   = 2'd0,
    ADDR_TOR   = 2'd1,
    ADDR_NA4   = 2'd2,
    ADDR_NAPOT = 2'd3
  } addr_mode_t;

  typedef struct packed { logic [31:0] q; } reg32_t;
  typedef struct packed { addr_mode_t a; logic x; logic w; logic r; } entry_cfg_t;
  typedef struct packed { reg32_t addrh; reg32_t addr; entry_cfg_t cfg; } iopmp_entry_t;

  typedef struct packed { logic [MD_BITS-1:0] q; } md_field_t;
  typedef struct packed { md_field_t md; } srcmd_en_t;
  typedef struct packed { srcmd_en_t en; } srcmd_entry_t;

  typedef struct packed { logic [15:0] q; } mdcfg_entry_t;

  typedef struct packed {
    logic        error_detected;
    logic [1:0]  ttype;
    logic [2:0]  etype;
    logic [15:0] err_reqid;
    logic [31:0] err_reqaddr;
    logic [31:0] err_reqaddrh;
  } error_capture_t;

  localparam logic [2:0] ETYPE_RD    = 3'h1;
  localparam logic [2:0] ETYPE_WR    = 3'h2;
  localparam logic [2:0] ETYPE_EX    = 3'h3;
  localparam logic [2:0] ETYPE_NOHIT = 3'h5;

  localparam logic [1:0] TTYPE_RD = 2'b01;
  localparam logic [1:0] TTYPE_WR = 2'b10;
  localparam logic [1:0] TTYPE_EX = 2'b11;

  typedef enum logic [1:0] {IDLE, WALK, RESP} checker_state_t;

  // Number of consecutive ones starting at bit 0 (64 when all set).
  function automatic logic [6:0] trailing_ones(input logic [63:0] v);
    logic [6:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < 64; i++) begin
      run = run & v[i];
      if (run) n = n + 7'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/rv_iopmp_entry_match.sv
// Single-entry granule address compare (OFF/TOR/NA4/NAPOT), purely combinational.
module rv_iopmp_entry_match
  import rv_iopmp_pkg::*;
(
  input  logic [63:0] i_g,
  input  logic [63:0] i_e,
  input  logic [63:0] i_e_prev,
  input  addr_mode_t  i_mode,
  output logic        o_hit
);

  logic [6:0] w_shift;

  always_comb begin
    // A shift of 64 or 65 clears both sides, so an all-ones NAPOT matches everything.
    w_shift = trailing_ones(i_e) + 7'd1;
    case (i_mode)
      ADDR_TOR:   o_hit = (i_g >= i_e_prev) && (i_g < i_e);
      ADDR_NA4:   o_hit = (i_g == i_e);
      ADDR_NAPOT: o_hit = ((i_g >> w_shift) == (i_e >> w_shift));
      default:    o_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_iopmp_seq_checker.sv
// Sequential IOPMP checker: walks one entry per cycle, lowest index wins.
// Optional denial counter is built only when RV_IOPMP_DENY_CNT_EN is defined.
module rv_iopmp_seq_checker
  import rv_iopmp_pkg::*;
#(
  parameter int NUM_ENTRY = 16,
  parameter int NUM_MD    = 8,
  parameter int NUM_SID   = 8,
  parameter int SID_W     = $clog2(NUM_SID)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic [SID_W-1:0] req_sid_i,
  input  logic [63:0]    req_addr_i,
  input  access_t        req_type_i,
  input  iopmp_entry_t   entry_i [NUM_ENTRY],
  input  srcmd_entry_t   srcmd_i [NUM_SID],
  input  mdcfg_entry_t   mdcfg_i [NUM_MD],
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic           rsp_allow_o,
  output error_capture_t rsp_err_o,
  output logic [15:0]    deny_cnt_o,
  output checker_state_t dbg_state_o
);

  localparam int IDX_W = $clog2(NUM_ENTRY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRY - 1);

  // Handshakes: a request transfers on req_valid_i & req_ready_o, a response on
  // rsp_valid_o & rsp_ready_i; ready is only high in IDLE so the two never overlap.
  checker_state_t   r_state;
  logic             r_req_ready;
  logic [IDX_W-1:0] r_idx;
  logic [SID_W-1:0] r_sid;
  logic [63:0]      r_addr;
  access_t          r_type;
  logic             r_rsp_valid;
  logic             r_rsp_allow;
  error_capture_t   r_rsp_err;

  logic [IDX_W-1:0] w_idx_prev;
  logic [63:0]      w_g, w_e, w_e_prev;
  entry_cfg_t       w_cfg;
  logic             w_md_found, w_eligible, w_hit, w_match;
  logic             w_type_ok, w_perm, w_done, w_allow;
  logic [1:0]       w_ttype;
  logic [2:0]       w_etype;
  error_capture_t   w_deny_err, w_err;
  logic             w_unused_srcmd;

  assign w_idx_prev = r_idx - IDX_W'(1);
  assign w_g        = {2'b00, r_addr[63:2]};
  assign w_e        = {entry_i[r_idx].addrh.q, entry_i[r_idx].addr.q};
  assign w_e_prev   = (r_idx == '0) ? 64'd0
                    : {entry_i[w_idx_prev].addrh.q, entry_i[w_idx_prev].addr.q};
  assign w_cfg      = entry_i[r_idx].cfg;

  rv_iopmp_entry_match u_match (
    .i_g      (w_g),
    .i_e      (w_e),
    .i_e_prev (w_e_prev),
    .i_mode   (w_cfg.a),
    .o_hit    (w_hit)
  );

  // Domain of the current entry is the first MD whose top index lies above it.
  always_comb begin
    w_md_found = 1'b0;
    w_eligible = 1'b0;
    for (int m = 0; m < NUM_MD; m++) begin
      if (!w_md_found && (16'(r_idx) < mdcfg_i[m].q)) begin
        w_md_found = 1'b1;
        w_eligible = srcmd_i[r_sid].en.md.q[m];
      end
    end
  end

  assign w_match = w_md_found & w_eligible & w_hit;

  always_comb begin
    w_type_ok = 1'b1;
    w_perm    = 1'b0;
    w_ttype   = TTYPE_RD;
    w_etype   = ETYPE_RD;
    case (r_type)
      ACCESS_READ:      w_perm = w_cfg.r;
      ACCESS_WRITE:     begin w_perm = w_cfg.w; w_ttype = TTYPE_WR; w_etype = ETYPE_WR; end
      ACCESS_EXECUTION: begin w_perm = w_cfg.x; w_ttype = TTYPE_EX; w_etype = ETYPE_EX; end
      default:          begin w_type_ok = 1'b0; w_ttype = 2'b00; w_etype = ETYPE_NOHIT; end
    endcase
    w_deny_err = '{error_detected: 1'b1, ttype: w_ttype, etype: w_etype,
                   err_reqid: 16'(r_sid), err_reqaddr: r_addr[31:0],
                   err_reqaddrh: r_addr[63:32]};
    w_done  = 1'b0;
    w_allow = 1'b0;
    w_err   = '0;
    if (!w_type_ok || (!w_match && (r_idx == LAST_IDX))) begin
      w_done      = 1'b1;
      w_err       = w_deny_err;
      w_err.etype = ETYPE_NOHIT;
    end else if (w_match) begin
      w_done  = 1'b1;
      w_allow = w_perm;
      w_err   = w_perm ? '0 : w_deny_err;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_idx       <= '0;
      r_sid       <= '0;
      r_addr      <= '0;
      r_type      <= ACCESS_NONE;
      r_rsp_valid <= 1'b0;
      r_rsp_allow <= 1'b0;
      r_rsp_err   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid_i && r_req_ready) begin
            r_sid       <= req_sid_i;
            r_addr      <= req_addr_i;
            r_type      <= req_type_i;
            r_idx       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= WALK;
          end
        end
        WALK: begin
          if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_allow <= w_allow;
            r_rsp_err   <= w_err;
            r_state     <= RESP;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_allow <= 1'b0;
            r_rsp_err   <= '0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_allow_o = r_rsp_allow;
  assign rsp_err_o   = r_rsp_err;
  assign dbg_state_o = r_state;

`ifdef RV_IOPMP_DENY_CNT_EN
  logic [15:0] r_deny_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_deny_cnt <= '0;
    end else if (r_rsp_valid && rsp_ready_i && !r_rsp_allow && (r_deny_cnt != 16'hFFFF)) begin
      r_deny_cnt <= r_deny_cnt + 16'd1;
    end
  end
  assign deny_cnt_o = r_deny_cnt;
`else
  assign deny_cnt_o = '0;
`endif

  // MD enable bits beyond NUM_MD have no meaning here.
  always_comb begin
    w_unused_srcmd = 1'b0;
    for (int s = 0; s < NUM_SID; s++) w_unused_srcmd = w_unused_srcmd ^ (^srcmd_i[s]);
  end

endmodule

// File: tb/tb_rv_iopmp_seq_checker.sv
// Bench for rv_iopmp_seq_checker: directed requests against a rule-level model.
// Deny counter expectations follow RV_IOPMP_DENY_CNT_EN.
module tb_rv_iopmp_seq_checker;
  import rv_iopmp_pkg::*;

  localparam int NUM_ENTRY = 16;
  localparam int NUM_MD    = 8;
  localparam int NUM_SID   = 8;
  localparam int SID_W     = 3;
  localparam int EXP_W     = 1 + $bits(error_capture_t);
`ifdef RV_IOPMP_DENY_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [SID_W-1:0] req_sid = '0;
  logic [63:0]      req_addr = '0;
  access_t          req_type = ACCESS_READ;
  iopmp_entry_t     tb_entry [NUM_ENTRY];
  srcmd_entry_t     tb_srcmd [NUM_SID];
  mdcfg_entry_t     tb_mdcfg [NUM_MD];
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic             rsp_allow;
  error_capture_t   rsp_err;
  logic [15:0]      deny_cnt;
  checker_state_t   dbg_state;

  rv_iopmp_seq_checker #(.NUM_ENTRY(NUM_ENTRY), .NUM_MD(NUM_MD), .NUM_SID(NUM_SID), .SID_W(SID_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_sid_i(req_sid), .req_addr_i(req_addr), .req_type_i(req_type),
    .entry_i(tb_entry), .srcmd_i(tb_srcmd), .mdcfg_i(tb_mdcfg),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_allow_o(rsp_allow),
    .rsp_err_o(rsp_err), .deny_cnt_o(deny_cnt), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  int exp_cyc_q[$];

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // ---------------- rule-level model ----------------
  function automatic logic [63:0] ent_addr(input int k);
    return {tb_entry[k].addrh.q, tb_entry[k].addr.q};
  endfunction

  function automatic bit entry_eligible(input int sid, input int k);
    for (int m = 0; m < NUM_MD; m++)
      if (k < int'(tb_mdcfg[m].q)) return tb_srcmd[sid].en.md.q[m];
    return 1'b0;
  endfunction

  function automatic bit addr_hits(input int k, input logic [63:0] g);
    logic [63:0] e, lo;
    int t;
    e  = ent_addr(k);
    lo = (k == 0) ? 64'd0 : ent_addr(k - 1);
    t  = 0;
    case (tb_entry[k].cfg.a)
      ADDR_TOR: return (g >= lo) && (g < e);
      ADDR_NA4: return g == e;
      ADDR_NAPOT: begin
        while (t < 64 && e[t]) t++;
        if (t >= 63) return 1'b1;
        return ((g ^ e) >> (t + 1)) == 64'd0;
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [EXP_W-1:0] model(input int sid, input logic [63:0] addr,
                                              input logic [2:0] ty, output int lat);
    error_capture_t e;
    logic allow;
    int hit_k;
    e = '0; allow = 1'b0; hit_k = -1;
    if (ty != 3'b001 && ty != 3'b010 && ty != 3'b100) begin
      lat = 2;
    end else begin
      for (int k = 0; k < NUM_ENTRY; k++)
        if (hit_k < 0 && entry_eligible(sid, k) && addr_hits(k, addr >> 2)) hit_k = k;
      lat = (hit_k < 0) ? NUM_ENTRY + 1 : hit_k + 2;
    end
    if (hit_k >= 0)
      allow = (ty == 3'b001) ? tb_entry[hit_k].cfg.r :
              (ty == 3'b010) ? tb_entry[hit_k].cfg.w : tb_entry[hit_k].cfg.x;
    if (!allow) begin
      e.error_detected = 1'b1;
      e.ttype = (ty == 3'b001) ? 2'b01 : (ty == 3'b010) ? 2'b10 : (ty == 3'b100) ? 2'b11 : 2'b00;
      e.etype = (hit_k < 0) ? 3'h5 : (ty == 3'b001) ? 3'h1 : (ty == 3'b010) ? 3'h2 : 3'h3;
      e.err_reqid    = 16'(sid);
      e.err_reqaddr  = addr[31:0];
      e.err_reqaddrh = addr[63:32];
    end
    return {allow, e};
  endfunction

  // ---------------- compare process ----------------
  initial begin
    bit seen;
    int exp_deny;
    logic [EXP_W-1:0] cur;
    seen = 1'b0;
    exp_deny = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
        exp_deny = 0;
      end else begin
        check("deny_cnt", deny_cnt, CNT_EN ? ((exp_deny > 65535) ? 65535 : exp_deny) : 0);
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_rsp");
          end else begin
            cur = exp_q[0];
            if (!seen) begin
              check("rsp_cycle", cyc, exp_cyc_q[0]);
              seen = 1'b1;
            end
            check("rsp_allow", rsp_allow, cur[EXP_W-1]);
            check("rsp_err", rsp_err, cur[EXP_W-2:0]);
            check("req_ready_in_resp", req_ready, 0);
            if (rsp_ready) begin
              if (!cur[EXP_W-1]) exp_deny++;
              void'(exp_q.pop_front());
              void'(exp_cyc_q.pop_front());
              seen = 1'b0;
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_tables();
    for (int k = 0; k < NUM_ENTRY; k++) tb_entry[k] = '0;
    for (int s = 0; s < NUM_SID; s++) tb_srcmd[s] = '0;
    for (int m = 0; m < NUM_MD; m++) tb_mdcfg[m] = '0;
  endtask

  task automatic set_entry(input int k, input logic [63:0] e, input addr_mode_t a,
                           input logic r, input logic w, input logic x);
    tb_entry[k].addrh.q = e[63:32];
    tb_entry[k].addr.q  = e[31:0];
    tb_entry[k].cfg.a   = a;
    tb_entry[k].cfg.r   = r;
    tb_entry[k].cfg.w   = w;
    tb_entry[k].cfg.x   = x;
  endtask

  task automatic send(input int sid, input logic [63:0] addr, input logic [2:0] ty);
    int n, lat;
    logic [EXP_W-1:0] x;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check("req_ready_wait", req_ready, 1);
    x = model(sid, addr, ty, lat);
    exp_q.push_back(x);
    exp_cyc_q.push_back(cyc + lat);
    req_valid = 1'b1;
    req_sid   = SID_W'(sid);
    req_addr  = addr;
    req_type  = access_t'(ty);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic take_rsp(input int hold);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < NUM_ENTRY + 8) begin @(posedge clk); #1; n++; end
    if (rsp_valid !== 1'b1) begin
      fail("rsp_timeout");
      return;
    end
    repeat (hold) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic txn(input int sid, input logic [63:0] addr, input logic [2:0] ty);
    send(sid, addr, ty);
    take_rsp(0);
  endtask

  // Hand-computed values that pin the model itself.
  task automatic pin(input string name, input int sid, input logic [63:0] addr, input logic [2:0] ty,
                     input logic exp_allow, input logic [2:0] exp_etype, input int exp_lat);
    logic [EXP_W-1:0] x;
    error_capture_t e;
    int lat;
    x = model(sid, addr, ty, lat);
    e = x[EXP_W-2:0];
    check({name, "_allow"}, x[EXP_W-1], exp_allow);
    check({name, "_etype"}, e.etype, exp_etype);
    check({name, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    error_capture_t e;
    logic [EXP_W-1:0] x;
    int lat;
    clear_tables();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_allow", rsp_allow, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_deny_cnt", deny_cnt, 0);
    check("rst_state", dbg_state, IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", req_ready, 1);

    // NAPOT entry 0 covering bytes 0..0x1FFF, read-only, sid0 in md0.
    set_entry(0, 64'h3FF, ADDR_NAPOT, 1'b1, 1'b0, 1'b0);
    tb_srcmd[0].en.md.q = 31'h1;
    tb_mdcfg[0].q = 16'd1;
    pin("pin_t1", 0, 64'h1000, 3'b001, 1'b1, 3'h0, 2);
    txn(0, 64'h1000, 3'b001);
    x = model(0, 64'h1000, 3'b010, lat);
    e = x[EXP_W-2:0];
    check("pin_t2_ttype", e.ttype, 2'b10);
    check("pin_t2_reqaddr", e.err_reqaddr, 32'h1000);
    check("pin_t2_etype", e.etype, 3'h2);
    txn(0, 64'h1000, 3'b010);
    txn(0, 64'h1FFC, 3'b001);
    pin("pin_napot_edge", 0, 64'h2000, 3'b001, 1'b0, 3'h5, NUM_ENTRY + 1);
    txn(0, 64'h2000, 3'b001);

    // TOR entry 3 over granules [0x100,0x400), execute-only.
    clear_tables();
    tb_srcmd[0].en.md.q = 31'h1;
    tb_mdcfg[0].q = 16'd16;
    set_entry(2, 64'h100, ADDR_OFF, 1'b0, 1'b0, 1'b0);
    set_entry(3, 64'h400, ADDR_TOR, 1'b0, 1'b0, 1'b1);
    pin("pin_t3", 0, 64'h800, 3'b100, 1'b1, 3'h0, 5);
    txn(0, 64'h800, 3'b100);
    pin("pin_t3_nohit", 0, 64'h1000, 3'b100, 1'b0, 3'h5, NUM_ENTRY + 1);
    txn(0, 64'h1000, 3'b100);
    txn(0, 64'h400, 3'b100);
    txn(0, 64'h3FC, 3'b100);

    // Overlap: entry 1 denies write, entry 4 allows it; lower index wins.
    set_entry(1, 64'h1FF, ADDR_NAPOT, 1'b1, 1'b0, 1'b0);
    set_entry(4, 64'h3FF, ADDR_NAPOT, 1'b0, 1'b1, 1'b0);
    pin("pin_t4", 0, 64'h800, 3'b010, 1'b0, 3'h2, 3);
    txn(0, 64'h800, 3'b010);
    pin("pin_t4_e4", 0, 64'h1800, 3'b010, 1'b1, 3'h0, 6);
    txn(0, 64'h1800, 3'b010);

    // Entry 0 in md2; sid5 first lacks md2, then gains it.
    clear_tables();
    tb_mdcfg[2].q = 16'd1;
    set_entry(0, 64'h400, ADDR_NA4, 1'b1, 1'b1, 1'b1);
    tb_srcmd[5].en.md.q = 31'h1;
    txn(5, 64'h1000, 3'b001);
    tb_srcmd[5].en.md.q = 31'h4;
    txn(5, 64'h1000, 3'b001);
    txn(5, 64'h1004, 3'b001);
    pin("pin_badtype", 5, 64'h1000, 3'b011, 1'b0, 3'h5, 2);
    txn(5, 64'h1000, 3'b011);

    // High address NA4, write denied; response held for 5 cycles.
    set_entry(0, 64'h1_0000_0008, ADDR_NA4, 1'b1, 1'b0, 1'b0);
    x = model(5, 64'h4_0000_0020, 3'b010, lat);
    e = x[EXP_W-2:0];
    check("pin_hi_reqaddrh", e.err_reqaddrh, 32'h4);
    check("pin_hi_reqid", e.err_reqid, 16'd5);
    send(5, 64'h4_0000_0020, 3'b010);
    take_rsp(5);
    txn(5, 64'h4_0000_0024, 3'b001);

    // Reset in the middle of a long walk: response must never appear.
    clear_tables();
    send(2, 64'h0, 3'b001);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_state", dbg_state, IDLE);
    check("abort_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_ready_after", req_ready, 1);
    check("abort_deny_cnt", deny_cnt, 0);

    txn(1, 64'h10, 3'b001);
    txn(2, 64'h20, 3'b010);
    txn(3, 64'h30, 3'b100);
    check("deny_cnt_after3", deny_cnt, CNT_EN ? 3 : 0);

    repeat (3) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
